// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: operand/PRN/ROB-id widths and the issue-queue entry record.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package ooo_pkg;

  localparam int MAX_OPERANDS = 3;
  localparam int PRN_BITS     = 6;
  localparam int INST_ID_BITS = 6;
  localparam int FU_COUNT     = 4;

  // One buffered instruction: payload plus a per-operand ready bit.
  typedef struct packed {
    logic [INST_ID_BITS-1:0]                  inst_id;
    logic [31:0]                              raw_instr;
    logic [63:0]                              instr_pc;
    logic [MAX_OPERANDS-1:0]                  prn_input_valid;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]    prn_input;
    logic [MAX_OPERANDS-1:0]                  prn_output_valid;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]    prn_output;
    logic [MAX_OPERANDS-1:0]                  rdy;
  } iq_entry_t;

endpackage

// File: rtl/iq_age_select.sv
// Age matrix over queue slots plus oldest-eligible one-hot select.
// Latency: select is combinational from the registered matrix; matrix updates on the edge.
// Backpressure: none; caller decides whether the grant is consumed.
module iq_age_select #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [DEPTH-1:0] valid,
  input  logic [DEPTH-1:0] eligible,
  input  logic             alloc_vld,
  input  logic [DEPTH-1:0] alloc_oh,
  output logic [DEPTH-1:0] grant_oh,
  output logic             found
);

  // older_q[i][j] set means slot j holds an instruction older than slot i
  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] older_d [DEPTH];

  // New entry is younger than every current entry; its column is cleared elsewhere
  always_comb begin
    older_d = older_q;
    if (alloc_vld) begin
      for (int i = 0; i < DEPTH; i++) begin
        older_d[i] = older_q[i] & ~alloc_oh;
        if (alloc_oh[i]) older_d[i] = valid & ~alloc_oh;
      end
    end
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) older_d[i] = '0;
    end
  end

  // Grant the eligible slot that has no eligible older slot
  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant_oh[i] = eligible[i] & ~(|(older_q[i] & eligible));
    end
    found = |grant_oh;
  end

  // Matrix register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
    end else begin
      older_q <= older_d;
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Per-FU out-of-order issue queue: tracks operand readiness from wakeups, issues oldest ready entry.
// Latency: insert at edge E0 -> out_valid after E1; last-operand wakeup in cycle t -> out_valid after t edge.
// Backpressure: output slot holds while out_valid & !out_ready; in_ready drops when all DEPTH slots are full.
module issue_queue #(
  parameter int DEPTH        = 8,
  parameter int MAX_OPERANDS = ooo_pkg::MAX_OPERANDS,
  parameter int PRN_BITS     = ooo_pkg::PRN_BITS,
  parameter int INST_ID_BITS = ooo_pkg::INST_ID_BITS,
  parameter int WAKE_PORTS   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INST_ID_BITS-1:0]  in_inst_id,
  input  logic [31:0]              in_raw_instr,
  input  logic [63:0]              in_instr_pc,
  input  logic                     in_prn_input_valid  [MAX_OPERANDS],
  input  logic                     in_prn_input_ready  [MAX_OPERANDS],
  input  logic [PRN_BITS-1:0]      in_prn_input        [MAX_OPERANDS],
  input  logic                     in_prn_output_valid [MAX_OPERANDS],
  input  logic [PRN_BITS-1:0]      in_prn_output       [MAX_OPERANDS],
  input  logic                     wake_valid          [WAKE_PORTS],
  input  logic [PRN_BITS-1:0]      wake_prn            [WAKE_PORTS],
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INST_ID_BITS-1:0]  out_inst_id,
  output logic [31:0]              out_raw_instr,
  output logic [63:0]              out_instr_pc,
  output logic                     out_prn_input_valid  [MAX_OPERANDS],
  output logic [PRN_BITS-1:0]      out_prn_input        [MAX_OPERANDS],
  output logic                     out_prn_output_valid [MAX_OPERANDS],
  output logic [PRN_BITS-1:0]      out_prn_output       [MAX_OPERANDS],
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int OCC_W = $clog2(DEPTH) + 1;

  // Entry storage
  logic [DEPTH-1:0]        valid_q, valid_d;
  logic [INST_ID_BITS-1:0] id_q    [DEPTH], id_d    [DEPTH];
  logic [31:0]             instr_q [DEPTH], instr_d [DEPTH];
  logic [63:0]             pc_q    [DEPTH], pc_d    [DEPTH];
  logic [MAX_OPERANDS-1:0] piv_q   [DEPTH], piv_d   [DEPTH];
  logic [MAX_OPERANDS-1:0] pov_q   [DEPTH], pov_d   [DEPTH];
  logic [MAX_OPERANDS-1:0] rdy_q   [DEPTH], rdy_d   [DEPTH];
  logic [PRN_BITS-1:0]     pin_q   [DEPTH][MAX_OPERANDS], pin_d  [DEPTH][MAX_OPERANDS];
  logic [PRN_BITS-1:0]     pout_q  [DEPTH][MAX_OPERANDS], pout_d [DEPTH][MAX_OPERANDS];
  logic [OCC_W-1:0]        occ_q, occ_d;

  // Output slot
  logic                    out_valid_q, out_valid_d;
  logic [INST_ID_BITS-1:0] out_id_q, out_id_d;
  logic [31:0]             out_instr_q, out_instr_d;
  logic [63:0]             out_pc_q, out_pc_d;
  logic                    out_piv_q  [MAX_OPERANDS], out_piv_d  [MAX_OPERANDS];
  logic [PRN_BITS-1:0]     out_pin_q  [MAX_OPERANDS], out_pin_d  [MAX_OPERANDS];
  logic                    out_pov_q  [MAX_OPERANDS], out_pov_d  [MAX_OPERANDS];
  logic [PRN_BITS-1:0]     out_pout_q [MAX_OPERANDS], out_pout_d [MAX_OPERANDS];

  // Control
  logic [MAX_OPERANDS-1:0] ent_hit [DEPTH];
  logic [MAX_OPERANDS-1:0] rdy_now [DEPTH];
  logic [MAX_OPERANDS-1:0] in_hit;
  logic [DEPTH-1:0]        eligible, alloc_oh, grant_oh;
  logic                    free_found, found, ins, load, issue;

  assign in_ready = rst & ~flush & (occ_q < OCC_W'(DEPTH));
  assign ins      = in_valid & in_ready;
  assign load     = ~out_valid_q | out_ready;
  assign issue    = load & found;

  // Wakeup matches for stored operands and the incoming instruction; unused operands never match
  always_comb begin
    in_hit = '0;
    for (int e = 0; e < DEPTH; e++) begin
      ent_hit[e] = '0;
      rdy_now[e] = '0;
    end
    eligible = '0;
    for (int o = 0; o < MAX_OPERANDS; o++) begin
      for (int k = 0; k < WAKE_PORTS; k++) begin
        if (wake_valid[k] && in_prn_input_valid[o] && wake_prn[k] == in_prn_input[o]) in_hit[o] = 1'b1;
      end
    end
    for (int e = 0; e < DEPTH; e++) begin
      for (int o = 0; o < MAX_OPERANDS; o++) begin
        for (int k = 0; k < WAKE_PORTS; k++) begin
          if (wake_valid[k] && piv_q[e][o] && wake_prn[k] == pin_q[e][o]) ent_hit[e][o] = 1'b1;
        end
      end
      rdy_now[e]  = rdy_q[e] | ent_hit[e];
      eligible[e] = valid_q[e] & (&rdy_now[e]);
    end
  end

  // Lowest-index free slot
  always_comb begin
    alloc_oh   = '0;
    free_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !free_found) begin
        alloc_oh[i] = 1'b1;
        free_found  = 1'b1;
      end
    end
  end

  iq_age_select #(.DEPTH(DEPTH)) u_age (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .valid     (valid_q),
    .eligible  (eligible),
    .alloc_vld (ins),
    .alloc_oh  (alloc_oh),
    .grant_oh  (grant_oh),
    .found     (found)
  );

  // Next-state: latch wakeups, free the issued slot, write the new entry, load the output slot
  always_comb begin
    valid_d = valid_q & ~(issue ? grant_oh : '0);
    id_d = id_q;  instr_d = instr_q;  pc_d = pc_q;
    piv_d = piv_q;  pov_d = pov_q;  pin_d = pin_q;  pout_d = pout_q;
    rdy_d = rdy_now;
    occ_d = occ_q + OCC_W'(ins) - OCC_W'(issue);
    out_valid_d = out_valid_q;  out_id_d = out_id_q;  out_instr_d = out_instr_q;  out_pc_d = out_pc_q;
    out_piv_d = out_piv_q;  out_pin_d = out_pin_q;  out_pov_d = out_pov_q;  out_pout_d = out_pout_q;
    for (int e = 0; e < DEPTH; e++) begin
      if (ins && alloc_oh[e]) begin
        valid_d[e] = 1'b1;
        id_d[e]    = in_inst_id;
        instr_d[e] = in_raw_instr;
        pc_d[e]    = in_instr_pc;
        for (int o = 0; o < MAX_OPERANDS; o++) begin
          piv_d[e][o]  = in_prn_input_valid[o];
          pov_d[e][o]  = in_prn_output_valid[o];
          pin_d[e][o]  = in_prn_input[o];
          pout_d[e][o] = in_prn_output[o];
          rdy_d[e][o]  = ~in_prn_input_valid[o] | in_prn_input_ready[o] | in_hit[o];
        end
      end
    end
    if (load) begin
      out_valid_d = found;
      for (int e = 0; e < DEPTH; e++) begin
        if (grant_oh[e]) begin
          out_id_d    = id_q[e];
          out_instr_d = instr_q[e];
          out_pc_d    = pc_q[e];
          for (int o = 0; o < MAX_OPERANDS; o++) begin
            out_piv_d[o]  = piv_q[e][o];
            out_pin_d[o]  = pin_q[e][o];
            out_pov_d[o]  = pov_q[e][o];
            out_pout_d[o] = pout_q[e][o];
          end
        end
      end
    end
    if (flush) begin
      valid_d     = '0;
      occ_d       = '0;
      out_valid_d = 1'b0;
    end
  end

  // State registers; payload storage needs no reset since valid bits gate it
  always_ff @(posedge clk) begin
    id_q <= id_d;  instr_q <= instr_d;  pc_q <= pc_d;
    piv_q <= piv_d;  pov_q <= pov_d;  pin_q <= pin_d;  pout_q <= pout_d;  rdy_q <= rdy_d;
    if (!rst) begin
      valid_q     <= '0;
      occ_q       <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      for (int o = 0; o < MAX_OPERANDS; o++) begin
        out_piv_q[o]  <= 1'b0;
        out_pin_q[o]  <= '0;
        out_pov_q[o]  <= 1'b0;
        out_pout_q[o] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      occ_q       <= occ_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      out_piv_q   <= out_piv_d;
      out_pin_q   <= out_pin_d;
      out_pov_q   <= out_pov_d;
      out_pout_q  <= out_pout_d;
    end
  end

  assign out_valid            = out_valid_q;
  assign out_inst_id          = out_id_q;
  assign out_raw_instr        = out_instr_q;
  assign out_instr_pc         = out_pc_q;
  assign out_prn_input_valid  = out_piv_q;
  assign out_prn_input        = out_pin_q;
  assign out_prn_output_valid = out_pov_q;
  assign out_prn_output       = out_pout_q;
  assign occupancy            = occ_q;

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: vector table for issue ordering plus hand sequences for full/flush/reset.
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: out_ready is driven per vector to exercise slot hold and refill.
module tb_issue_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_inst_id;
  logic [31:0] in_raw_instr;
  logic [63:0] in_instr_pc;
  logic       in_prn_input_valid  [3];
  logic       in_prn_input_ready  [3];
  logic [5:0] in_prn_input        [3];
  logic       in_prn_output_valid [3];
  logic [5:0] in_prn_output       [3];
  logic       wake_valid          [3];
  logic [5:0] wake_prn            [3];
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_inst_id;
  logic [31:0] out_raw_instr;
  logic [63:0] out_instr_pc;
  logic       out_prn_input_valid  [3];
  logic [5:0] out_prn_input        [3];
  logic       out_prn_output_valid [3];
  logic [5:0] out_prn_output       [3];
  logic [3:0] occupancy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  issue_queue dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst_id(in_inst_id), .in_raw_instr(in_raw_instr), .in_instr_pc(in_instr_pc),
    .in_prn_input_valid(in_prn_input_valid), .in_prn_input_ready(in_prn_input_ready),
    .in_prn_input(in_prn_input),
    .in_prn_output_valid(in_prn_output_valid), .in_prn_output(in_prn_output),
    .wake_valid(wake_valid), .wake_prn(wake_prn),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst_id(out_inst_id), .out_raw_instr(out_raw_instr), .out_instr_pc(out_instr_pc),
    .out_prn_input_valid(out_prn_input_valid), .out_prn_input(out_prn_input),
    .out_prn_output_valid(out_prn_output_valid), .out_prn_output(out_prn_output),
    .occupancy(occupancy)
  );

  typedef struct {
    logic       iv;
    logic [5:0] id;
    logic       pv;
    logic       pr;
    logic [5:0] prn;
    logic       wv;
    logic [5:0] wp;
    logic       ordy;
    logic       eov;
    logic [5:0] eid;
    logic [3:0] eocc;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input logic iv, input logic [5:0] id, input logic pv, input logic pr,
                     input logic [5:0] prn, input logic wv, input logic [5:0] wp, input logic ordy,
                     input logic eov, input logic [5:0] eid, input logic [3:0] eocc);
    vec_t v;
    v.iv = iv; v.id = id; v.pv = pv; v.pr = pr; v.prn = prn; v.wv = wv; v.wp = wp;
    v.ordy = ordy; v.eov = eov; v.eid = eid; v.eocc = eocc;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Operand 0 is the tracked source; operands 1/2 are unused. Payload encodes the id.
  task automatic set_in(input logic iv, input logic [5:0] id, input logic pv, input logic pr,
                        input logic [5:0] prn, input logic wv, input logic [5:0] wp,
                        input logic ordy, input logic fl);
    in_valid     = iv;
    in_inst_id   = id;
    in_raw_instr = 32'hA000_0000 | {26'd0, id};
    in_instr_pc  = 64'h1000 + {56'd0, id, 2'b00};
    for (int o = 0; o < 3; o++) begin
      in_prn_input_valid[o]  = (o == 0) ? pv : 1'b0;
      in_prn_input_ready[o]  = (o == 0) ? pr : 1'b0;
      in_prn_input[o]        = prn;
      in_prn_output_valid[o] = (o == 0);
      in_prn_output[o]       = id;
      wake_valid[o]          = (o == 0) ? wv : 1'b0;
      wake_prn[o]            = wp;
    end
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_payload(input string nm, input logic [5:0] id);
    chk({nm, "_id"},  {58'd0, out_inst_id}, {58'd0, id});
    chk({nm, "_raw"}, {32'd0, out_raw_instr}, {32'd0, 32'hA000_0000 | {26'd0, id}});
    chk({nm, "_pc"},  out_instr_pc, 64'h1000 + {56'd0, id, 2'b00});
    chk({nm, "_pout"}, {58'd0, out_prn_output[0]}, {58'd0, id});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_occ", {60'd0, occupancy}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_id", {58'd0, out_inst_id}, 64'd0);
    chk("rst_out_raw", {32'd0, out_raw_instr}, 64'd0);
    rst = 1'b1;
    #1;
    chk("rel_in_ready", {63'd0, in_ready}, 64'd1);

    //  iv id  pv pr prn wv wp ordy  eov eid occ
    add(1, 1,  0, 0, 0,  0, 0,  1,   0,  0,  1);  // in-order: ids 1,2,3
    add(1, 2,  0, 0, 0,  0, 0,  1,   1,  1,  1);
    add(1, 3,  0, 0, 0,  0, 0,  1,   1,  2,  1);
    add(0, 0,  0, 0, 0,  0, 0,  1,   1,  3,  0);
    add(0, 0,  0, 0, 0,  0, 0,  1,   0,  0,  0);
    add(1, 4,  1, 0, 10, 0, 0,  1,   0,  0,  1);  // 4 waits on PRN 10
    add(1, 5,  0, 0, 0,  0, 0,  1,   0,  0,  2);
    add(0, 0,  0, 0, 0,  1, 11, 1,   1,  5,  1);  // unrelated wake, 5 passes 4
    add(0, 0,  0, 0, 0,  1, 10, 1,   1,  4,  0);
    add(0, 0,  0, 0, 0,  0, 0,  1,   0,  0,  0);
    add(1, 6,  1, 0, 12, 0, 0,  1,   0,  0,  1);  // 6 and 7 both wait on PRN 12
    add(1, 7,  1, 0, 12, 0, 0,  1,   0,  0,  2);
    add(0, 0,  0, 0, 0,  1, 12, 1,   1,  6,  1);
    add(0, 0,  0, 0, 0,  0, 0,  1,   1,  7,  0);
    add(0, 0,  0, 0, 0,  0, 0,  1,   0,  0,  0);
    add(1, 9,  1, 0, 20, 1, 20, 1,   0,  0,  1);  // same-cycle wake bypass on insert
    add(0, 0,  0, 0, 0,  0, 0,  1,   1,  9,  0);
    add(0, 0,  0, 0, 0,  0, 0,  1,   0,  0,  0);

    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].iv, tbl[i].id, tbl[i].pv, tbl[i].pr, tbl[i].prn,
             tbl[i].wv, tbl[i].wp, tbl[i].ordy, 1'b0);
      step();
      chk($sformatf("v%0d_out_valid", i), {63'd0, out_valid}, {63'd0, tbl[i].eov});
      chk($sformatf("v%0d_occ", i), {60'd0, occupancy}, {60'd0, tbl[i].eocc});
      if (tbl[i].eov) chk_payload($sformatf("v%0d", i), tbl[i].eid);
    end

    // Back-pressure and fill: 9 inserts with out_ready low, id 20 parks in the slot
    for (int i = 0; i < 9; i++) begin
      set_in(1, 6'(20 + i), 0, 0, 0, 0, 0, 0, 0);
      step();
      chk($sformatf("bp%0d_occ", i), {60'd0, occupancy}, (i == 0) ? 64'd1 : 64'(i));
      if (i > 0) begin
        chk($sformatf("bp%0d_out_valid", i), {63'd0, out_valid}, 64'd1);
        chk_payload($sformatf("bp%0d_hold", i), 6'd20);
      end
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    chk("full_occ", {60'd0, occupancy}, 64'd8);
    for (int j = 0; j < 8; j++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
      step();
      chk($sformatf("drain%0d_valid", j), {63'd0, out_valid}, 64'd1);
      chk($sformatf("drain%0d_id", j), {58'd0, out_inst_id}, 64'(21 + j));
      chk($sformatf("drain%0d_occ", j), {60'd0, occupancy}, 64'(7 - j));
      chk($sformatf("drain%0d_in_ready", j), {63'd0, in_ready}, 64'd1);
    end
    step();
    chk("drain_end_valid", {63'd0, out_valid}, 64'd0);

    // Flush with 5 entries queued and the slot full; concurrent insert must be dropped
    for (int i = 0; i < 6; i++) begin
      set_in(1, 6'(30 + i), 0, 0, 0, 0, 0, 0, 0);
      step();
    end
    chk("pre_flush_occ", {60'd0, occupancy}, 64'd5);
    chk("pre_flush_valid", {63'd0, out_valid}, 64'd1);
    set_in(1, 36, 0, 0, 0, 0, 0, 1, 1);
    #1;
    chk("flush_in_ready", {63'd0, in_ready}, 64'd0);
    step();
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_occ", {60'd0, occupancy}, 64'd0);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(); step();
    chk("post_flush_valid", {63'd0, out_valid}, 64'd0);
    chk("post_flush_occ", {60'd0, occupancy}, 64'd0);
    chk("post_flush_in_ready", {63'd0, in_ready}, 64'd1);

    // Reset mid-operation discards contents
    for (int i = 0; i < 3; i++) begin
      set_in(1, 6'(40 + i), 0, 0, 0, 0, 0, 0, 0);
      step();
    end
    chk("pre_rst_occ", {60'd0, occupancy}, 64'd2);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step();
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_occ", {60'd0, occupancy}, 64'd0);
    chk("mid_rst_id", {58'd0, out_inst_id}, 64'd0);
    chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(); step();
    chk("post_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("post_rst_occ", {60'd0, occupancy}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
